// File: rtl/barrel_shift_arbiter.sv
// barrel_shift_arbiter: round-robin arbiter that shares one N-bit rotate datapath
// between R valid/ready requesters. Results go into a single-entry output register.

// One requester lane. Its operand fields are gated by its grant bit, so ungranted
// (possibly unknown) fields drive zero into the shared OR-mux.
module bsa_lane #(
    parameter int N = 32,
    parameter int M = 5
) (
    input  logic         i_gnt,
    input  logic [N-1:0] i_a,
    input  logic [M-1:0] i_amt,
    input  logic         i_lr,
    output logic [N-1:0] o_a,
    output logic [M-1:0] o_amt,
    output logic         o_lr
);
    // Gate every field with the grant so only the winner reaches the shifter.
    always_comb begin
        o_a   = i_gnt ? i_a   : '0;
        o_amt = i_gnt ? i_amt : '0;
        o_lr  = i_gnt ? i_lr  : 1'b0;
    end
endmodule

module barrel_shift_arbiter #(
    parameter int N   = 32,
    parameter int M   = 5,
    parameter int R   = 4,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [R-1:0]   req_valid,
    output logic [R-1:0]   req_ready,
    input  logic [R*N-1:0] req_a,
    input  logic [R*M-1:0] req_amt,
    input  logic [R-1:0]   req_lr,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [N-1:0]   rsp_y,
    output logic [IDW-1:0] rsp_id
);
    logic [IDW-1:0]        r_ptr;
    logic                  r_rsp_valid;
    logic [N-1:0]          r_rsp_y;
    logic [IDW-1:0]        r_rsp_id;

    logic                  w_slot_free;
    logic                  w_any;
    logic [IDW-1:0]        w_win;
    logic [R-1:0]          w_gnt;
    logic                  w_accept;
    logic [IDW-1:0]        w_ptr_nxt;

    logic [R-1:0][N-1:0]   w_lane_a;
    logic [R-1:0][M-1:0]   w_lane_amt;
    logic [R-1:0]          w_lane_lr;
    logic [N-1:0]          w_sel_a;
    logic [M-1:0]          w_sel_amt;
    logic                  w_sel_lr;
    logic [N-1:0]          w_rot;

    // A full slot can still take a new result if the consumer drains it this cycle.
    assign w_slot_free = !r_rsp_valid || rsp_ready;

    // Round-robin scan: walk offsets from the far end back to ptr so the
    // closest valid requester (lowest offset) is the last, winning assignment.
    always_comb begin
        int idx;
        w_any = 1'b0;
        w_win = '0;
        for (int k = R - 1; k >= 0; k--) begin
            idx = int'(r_ptr) + k;
            if (idx >= R) idx = idx - R;
            if (req_valid[idx]) begin
                w_any = 1'b1;
                w_win = IDW'(idx);
            end
        end
    end

    // Grant is one-hot to the winner only when the result slot can take it.
    always_comb begin
        w_gnt = '0;
        if (w_any && w_slot_free) w_gnt = R'(1) << w_win;
    end

    assign req_ready = w_gnt;
    assign w_accept  = |w_gnt;
    assign w_ptr_nxt = (w_win == IDW'(R - 1)) ? '0 : w_win + 1'b1;

    genvar g;
    generate
        for (g = 0; g < R; g++) begin : g_lane
            bsa_lane #(.N(N), .M(M)) u_lane (
                .i_gnt (w_gnt[g]),
                .i_a   (req_a[g*N +: N]),
                .i_amt (req_amt[g*M +: M]),
                .i_lr  (req_lr[g]),
                .o_a   (w_lane_a[g]),
                .o_amt (w_lane_amt[g]),
                .o_lr  (w_lane_lr[g])
            );
        end
    endgenerate

    // OR-combine the gated lanes; at most one lane is non-zero.
    always_comb begin
        w_sel_a   = '0;
        w_sel_amt = '0;
        w_sel_lr  = 1'b0;
        for (int i = 0; i < R; i++) begin
            w_sel_a   = w_sel_a   | w_lane_a[i];
            w_sel_amt = w_sel_amt | w_lane_amt[i];
            w_sel_lr  = w_sel_lr  | w_lane_lr[i];
        end
    end

    // Log-stage rotator: stage s rotates by 2**s when amt[s] is set. Each stage
    // shift is between 1 and N/2, so no shift-by-N term ever appears.
    always_comb begin
        w_rot = w_sel_a;
        for (int s = 0; s < M; s++) begin
            if (w_sel_amt[s]) begin
                if (w_sel_lr)
                    w_rot = (w_rot << (1 << s)) | (w_rot >> (N - (1 << s)));
                else
                    w_rot = (w_rot >> (1 << s)) | (w_rot << (N - (1 << s)));
            end
        end
    end

    // Result register and priority pointer: accept overrides drain, so a
    // simultaneous drain+accept keeps rsp_valid high with the new result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_y     <= '0;
            r_rsp_id    <= '0;
            r_ptr       <= '0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_y     <= w_rot;
            r_rsp_id    <= w_win;
            r_ptr       <= w_ptr_nxt;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_y     = r_rsp_y;
    assign rsp_id    = r_rsp_id;
endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Bench for barrel_shift_arbiter: directed vector table, hand-written reset
// sequence, then randomized traffic against a behavioural model.
module tb_barrel_shift_arbiter;
    localparam int N   = 32;
    localparam int M   = 5;
    localparam int R   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [R-1:0]   req_valid;
    logic [R-1:0]   req_ready;
    logic [R*N-1:0] req_a;
    logic [R*M-1:0] req_amt;
    logic [R-1:0]   req_lr;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [N-1:0]   rsp_y;
    logic [IDW-1:0] rsp_id;

    int n_tests = 0;
    int n_fail  = 0;

    barrel_shift_arbiter #(.N(N), .M(M), .R(R), .IDW(IDW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_amt   (req_amt),
        .req_lr    (req_lr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          nm;
        logic [R-1:0]   vld;
        int             who;
        logic [N-1:0]   a;
        logic [M-1:0]   amt;
        logic           lr;
        logic           rdy;
        logic [R-1:0]   gnt;
        logic           v;
        logic [N-1:0]   y;
        logic [IDW-1:0] id;
    } row_t;

    row_t rows[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic add(input string nm, input logic [R-1:0] vld, input int who,
                       input logic [N-1:0] a, input logic [M-1:0] amt, input logic lr,
                       input logic rdy, input logic [R-1:0] gnt, input logic v,
                       input logic [N-1:0] y, input logic [IDW-1:0] id);
        row_t r;
        r.nm = nm; r.vld = vld; r.who = who; r.a = a; r.amt = amt; r.lr = lr;
        r.rdy = rdy; r.gnt = gnt; r.v = v; r.y = y; r.id = id;
        rows.push_back(r);
    endtask

    // Default operands: lane i holds 1 << 8i, rotates left by i+1.
    task automatic drive_row(input row_t r);
        logic [N-1:0] one;
        one = 1;
        for (int i = 0; i < R; i++) begin
            req_a[i*N +: N]   = one << (8 * i);
            req_amt[i*M +: M] = M'(i + 1);
            req_lr[i]         = 1'b1;
        end
        if (r.who >= 0) begin
            req_a[r.who*N +: N]   = r.a;
            req_amt[r.who*M +: M] = r.amt;
            req_lr[r.who]         = r.lr;
        end
        req_valid = r.vld;
        rsp_ready = r.rdy;
    endtask

    function automatic logic [N-1:0] rot_ref(input logic [N-1:0] a, input int amt, input logic lr);
        logic [N-1:0] y;
        y = '0;
        for (int i = 0; i < N; i++) begin
            if (lr) y[(i + amt) % N] = a[i];
            else    y[i] = a[(i + amt) % N];
        end
        return y;
    endfunction

    // Model state for the random phase
    logic           hv  [R];
    logic [N-1:0]   ha  [R];
    int             hamt[R];
    logic           hlr [R];
    logic           mv;
    logic [N-1:0]   my;
    int             mid;
    int             mptr;

    initial begin
        reset_n = 1'b0; req_valid = '0; req_a = '0; req_amt = '0; req_lr = '0; rsp_ready = 1'b0;

        add("left1",      4'b0001,  0, 32'h0000_00F0, 4, 1, 1, 4'b0001, 1, 32'h0000_0F00, 0);
        add("drain",      4'b0000, -1, 0,             0, 0, 1, 4'b0000, 0, 32'h0000_0F00, 0);
        add("empty_nrdy", 4'b0001,  0, 32'h0000_00F0, 8, 1, 0, 4'b0001, 1, 32'h0000_F000, 0);
        add("rwrap",      4'b0100,  2, 32'h0000_00F1, 4, 0, 1, 4'b0100, 1, 32'h1000_000F, 2);
        add("amt0",       4'b0100,  2, 32'hDEAD_BEEF, 0, 0, 1, 4'b0100, 1, 32'hDEAD_BEEF, 2);
        add("drain2",     4'b0000, -1, 0,             0, 0, 1, 4'b0000, 0, 32'hDEAD_BEEF, 2);
        add("ptr_to0",    4'b1000, -1, 0,             0, 0, 1, 4'b1000, 1, 32'h1000_0000, 3);
        add("rr0",        4'b1111, -1, 0,             0, 0, 1, 4'b0001, 1, 32'h0000_0002, 0);
        add("rr1",        4'b1111, -1, 0,             0, 0, 1, 4'b0010, 1, 32'h0000_0400, 1);
        add("rr2",        4'b1111, -1, 0,             0, 0, 1, 4'b0100, 1, 32'h0008_0000, 2);
        add("rr3",        4'b1111, -1, 0,             0, 0, 1, 4'b1000, 1, 32'h1000_0000, 3);
        add("rr4",        4'b1111, -1, 0,             0, 0, 1, 4'b0001, 1, 32'h0000_0002, 0);
        add("rr5",        4'b1111, -1, 0,             0, 0, 1, 4'b0010, 1, 32'h0000_0400, 1);
        add("pre_bp",     4'b0001, -1, 0,             0, 0, 1, 4'b0001, 1, 32'h0000_0002, 0);
        add("bp_a",       4'b1010, -1, 0,             0, 0, 0, 4'b0000, 1, 32'h0000_0002, 0);
        add("bp_b",       4'b1010, -1, 0,             0, 0, 0, 4'b0000, 1, 32'h0000_0002, 0);
        add("bp_c",       4'b1010, -1, 0,             0, 0, 0, 4'b0000, 1, 32'h0000_0002, 0);
        add("bp_rel1",    4'b1010, -1, 0,             0, 0, 1, 4'b0010, 1, 32'h0000_0400, 1);
        add("bp_rel3",    4'b1000, -1, 0,             0, 0, 1, 4'b1000, 1, 32'h1000_0000, 3);
        add("skip3",      4'b1000, -1, 0,             0, 0, 1, 4'b1000, 1, 32'h1000_0000, 3);
        add("skip1",      4'b0010, -1, 0,             0, 0, 1, 4'b0010, 1, 32'h0000_0400, 1);
        add("ptr2",       4'b0101, -1, 0,             0, 0, 1, 4'b0100, 1, 32'h0008_0000, 2);
        add("then0",      4'b0001, -1, 0,             0, 0, 1, 4'b0001, 1, 32'h0000_0002, 0);
        add("pre_rst",    4'b0100, -1, 0,             0, 0, 1, 4'b0100, 1, 32'h0008_0000, 2);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_y",     rsp_y,     0);
        chk("rst_id",    rsp_id,    0);
        chk("rst_ready", req_ready, 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed table: ready checked mid-cycle, result after the edge
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge clk);
            chk({rows[i].nm, ".ready"}, req_ready, rows[i].gnt);
            @(posedge clk); #1;
            chk({rows[i].nm, ".valid"}, rsp_valid, rows[i].v);
            chk({rows[i].nm, ".y"},     rsp_y,     rows[i].y);
            chk({rows[i].nm, ".id"},    rsp_id,    rows[i].id);
        end

        // Asynchronous reset between edges with a full slot and ptr=3
        req_valid = '0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", rsp_valid, 0);
        chk("arst_y",     rsp_y,     0);
        chk("arst_id",    rsp_id,    0);
        @(negedge clk);
        reset_n   = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        chk("arst_first_gnt", req_ready, 4'b0001);
        @(posedge clk); #1;
        chk("arst_first_id", rsp_id, 0);
        chk("arst_first_y",  rsp_y,  32'h0000_0002);

        // Fresh reset, then randomized traffic against the model
        reset_n = 1'b0; req_valid = '0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < R; i++) begin hv[i] = 0; ha[i] = '0; hamt[i] = 0; hlr[i] = 0; end
        mv = 0; my = '0; mid = 0; mptr = 0;
        @(posedge clk); #1;

        for (int c = 0; c < 400; c++) begin
            logic [R-1:0] eg;
            int           win;
            for (int i = 0; i < R; i++) begin
                if (!hv[i] && $urandom_range(1, 0) == 1) begin
                    hv[i] = 1; ha[i] = $urandom; hamt[i] = $urandom_range(N - 1, 0);
                    hlr[i] = 1'($urandom_range(1, 0));
                end
                req_valid[i] = hv[i];
                // Idle lanes carry junk that must be ignored
                req_a[i*N +: N]   = hv[i] ? ha[i] : N'($urandom);
                req_amt[i*M +: M] = hv[i] ? M'(hamt[i]) : M'($urandom);
                req_lr[i]         = hv[i] ? hlr[i] : 1'($urandom);
            end
            rsp_ready = ($urandom_range(3, 0) != 0);

            eg = '0; win = -1;
            if (!mv || rsp_ready) begin
                for (int k = 0; k < R && win < 0; k++)
                    if (hv[(mptr + k) % R]) win = (mptr + k) % R;
            end
            if (win >= 0) eg[win] = 1'b1;

            @(negedge clk);
            chk("rnd.ready", req_ready, eg);
            chk("rnd.valid", rsp_valid, mv);
            chk("rnd.y",     rsp_y,     my);
            chk("rnd.id",    rsp_id,    mid);
            @(posedge clk); #1;

            if (win >= 0) begin
                my = rot_ref(ha[win], hamt[win], hlr[win]);
                mid = win; mv = 1; mptr = (win + 1) % R; hv[win] = 0;
            end else if (rsp_ready) begin
                mv = 0;
            end
        end
        @(negedge clk);
        chk("rnd.final_valid", rsp_valid, mv);
        chk("rnd.final_y",     rsp_y,     my);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/barrel_shift_arbiter.md
Name: barrel_shift_arbiter

Overview:
- Shares one N-bit rotate datapath between R requesters using valid/ready handshakes.
- Round-robin arbitration; one operation accepted per cycle; registered single-entry result stage.
- Sits between several client blocks (address generators, bit-field extractors) and the shifter, so only one shifter instance is needed.

Parameters:
- N, 32, data width; must equal 2**M.
- M, 5, shift-amount width.
- R, 4, number of requesters; 2..8.
- IDW, 2, requester-id width; must be >= clog2(R).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  R  request i valid.
- req_ready  out  R  request i accepted this cycle; combinational, one-hot or zero.
- req_a  in  R*N  operand of requester i, at bits [i*N +: N].
- req_amt  in  R*M  rotate amount of requester i, at bits [i*M +: M].
- req_lr  in  R  direction of requester i: 1 = rotate left, 0 = rotate right.
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  consumer takes the result this cycle.
- rsp_y  out  N  rotated result.
- rsp_id  out  IDW  index of the requester that owns rsp_y.

Behaviour:
- Reset (async assert, sync release):
  - rsp_valid=0, rsp_y=0, rsp_id=0.
  - Priority pointer ptr=0.
  - Any held result is discarded.
- Slot state:
  - EMPTY when rsp_valid=0.
  - FULL when rsp_valid=1.
  - slot_free = !rsp_valid || rsp_ready.
- Arbitration (combinational, every cycle):
  - Winner = first i with req_valid[i]=1, scanning ptr, ptr+1, ... mod R.
  - req_ready[winner]=1 only if slot_free; all other req_ready bits = 0.
  - If no req_valid bit is set, or the slot is not free, req_ready=0.
- Accept (handshake req_valid[w] && req_ready[w] at edge k):
  - rsp_y <= rotate(req_a[w], req_amt[w], req_lr[w]).
  - rsp_id <= w; rsp_valid <= 1 (visible after edge k, latency 1).
  - ptr <= (w+1) mod R.
- Drain without accept (rsp_valid && rsp_ready, no accept): rsp_valid <= 0; rsp_y and rsp_id keep their values.
- Simultaneous drain and accept: the new result replaces the old one with rsp_valid held at 1. This gives one result per cycle.
- FULL with rsp_ready=0:
  - rsp_y, rsp_id and rsp_valid stay stable.
  - req_ready=0; ptr unchanged.
- Rotate arithmetic:
  - Left: y = (a << amt) | (a >> (N-amt)).
  - Right: y = (a >> amt) | (a << (N-amt)).
  - amt=0 gives y=a, with no undefined shift-by-N term.
- Requester rules:
  - Once req_valid[i] rises, it stays high with its operands stable until accepted.
  - The block does not latch unaccepted operands.
- Fairness: a requester held continuously valid is granted within R accepts.
- Operand sampling: fields of non-granted requesters are ignored; X on them must not propagate.

Test Plan:
- Single left rotate: req_valid=0001, a=32'h0000_00F0, amt=4, lr=1, rsp_ready=1 -> req_ready=0001 in that cycle; next cycle rsp_valid=1, rsp_y=32'h0000_0F00, rsp_id=0.
- Right-rotate wrap and amt=0: requester 2 sends a=32'h0000_00F1, amt=4, lr=0 -> rsp_y=32'h1000_000F, rsp_id=2. Then a=32'hDEAD_BEEF, amt=0 -> rsp_y=32'hDEAD_BEEF.
- Round-robin: all four valid continuously, rsp_ready=1, distinct operands -> rsp_id sequence 0,1,2,3,0,1 on consecutive cycles; each rsp_y matches its own requester's operands.
- Backpressure: result held with rsp_ready=0 for 3 cycles while requesters 1 and 3 are valid -> req_ready=0 throughout and rsp_y/rsp_id stable. When rsp_ready rises, requester 1 is accepted that same cycle, then requester 3 the next cycle.
- Skipping and pointer update: only requester 3 valid, then only requester 1 -> grants 3 then 1. Afterwards, with 0 and 2 both valid, ptr=2 so requester 2 is granted first.
- Reset mid-operation: rsp_valid=1 and ptr=3, assert reset_n=0 between clock edges -> rsp_valid=0, rsp_y=0, rsp_id=0 immediately. After release with all requesters valid, the first grant goes to requester 0.
